// File: rtl/biquad_coeff_sequencer.sv
// Coefficient load sequencer for the biquad DSP cascades.
// Software fills per-channel shadow registers and then commits a channel mask.
// The block then shifts each selected channel's coefficients out on a shared
// data bus, using per-channel write and update strobes.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   reg_wr_i        shadow write strobe (accepted only while idle)
//   reg_addr_i      shadow address = chan*NCOEFF + idx
//   reg_dat_i       shadow write data
//   commit_i        start a load of the channels in commit_mask_i
//   commit_mask_i   channels to load, sampled together with commit_i
//   err_clr_i       clears the sticky error flag
//   busy_o          sequence in progress
//   done_o          one-cycle pulse at the end of a sequence
//   err_o           sticky: dropped write/commit or out-of-range address
//   coeff_dat_o     shared coefficient bus, lags coeff_wr_o by one cycle
//   coeff_wr_o      per-channel coefficient shift strobe
//   coeff_update_o  per-channel coefficient apply strobe
module biquad_coeff_sequencer #(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned NCOEFF     = 2,
  parameter int unsigned CBITS      = 18,
  parameter int unsigned UPDATE_GAP = 1,
  parameter int unsigned ADDR_W     = $clog2(NCHAN * NCOEFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_wr_i,
  input  logic [ADDR_W-1:0] reg_addr_i,
  input  logic [CBITS-1:0]  reg_dat_i,
  input  logic              commit_i,
  input  logic [NCHAN-1:0]  commit_mask_i,
  input  logic              err_clr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CBITS-1:0]  coeff_dat_o,
  output logic [NCHAN-1:0]  coeff_wr_o,
  output logic [NCHAN-1:0]  coeff_update_o
);

  localparam int unsigned NREG = NCHAN * NCOEFF;
  localparam int unsigned CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned K_W  = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
  localparam int unsigned G_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_GAP,
    S_UPDATE,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [NCHAN-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]    chan_q, chan_d;
  logic [K_W-1:0]     cnt_q, cnt_d;
  logic [G_W-1:0]     gap_q, gap_d;
  logic [CBITS-1:0]   shadow_q [NREG];
  logic [CBITS-1:0]   shadow_d [NREG];

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CBITS-1:0]   dat_q, dat_d;
  logic [NCHAN-1:0]   wr_q, wr_d;
  logic [NCHAN-1:0]   upd_q, upd_d;

  logic [CH_W-1:0]    sel_chan;
  logic [ADDR_W-1:0]  rd_addr;
  logic               addr_ok;
  logic               err_set;

  // Lowest-numbered channel still pending in the latched mask.
  always_comb begin
    sel_chan = '0;
    for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_chan = CH_W'(i);
    end
  end

  assign rd_addr = ADDR_W'(32'(chan_q) * NCOEFF + 32'(cnt_q));
  assign addr_ok = 32'(reg_addr_i) < NREG;

  // Next state, shadow update, and next-cycle output decode.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    dat_d    = dat_q;
    shadow_d = shadow_q;
    err_set  = 1'b0;
    wr_d     = '0;
    upd_d    = '0;

    // Shadow writes land only while idle; busy_q is low in IDLE and FINISH.
    if (reg_wr_i) begin
      if (busy_q || !addr_ok) err_set = 1'b1;
      else shadow_d[reg_addr_i] = reg_dat_i;
    end
    if (commit_i && busy_q) err_set = 1'b1;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (commit_i && (commit_mask_i != '0)) begin
          mask_d  = commit_mask_i;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        chan_d  = sel_chan;
        mask_d  = mask_q & ~(NCHAN'(1) << sel_chan);
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // The cascade captures B one cycle after its write enable.
        dat_d = shadow_q[rd_addr];
        if (cnt_q == K_W'(NCOEFF - 1)) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + K_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == G_W'(UPDATE_GAP - 1)) state_d = S_UPDATE;
        else gap_d = gap_q + G_W'(1);
      end
      S_UPDATE: begin
        state_d = (mask_q != '0) ? S_SELECT : S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    busy_d = (state_d == S_SELECT) || (state_d == S_LOAD) ||
             (state_d == S_GAP) || (state_d == S_UPDATE);
    done_d = (state_d == S_FINISH);
    if (state_d == S_LOAD)   wr_d  = NCHAN'(1) << chan_d;
    if (state_d == S_UPDATE) upd_d = NCHAN'(1) << chan_d;

    // A new error in the same cycle as a clear takes priority.
    if (err_set)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  // State, shadow array and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      chan_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      wr_q    <= '0;
      upd_q   <= '0;
      for (int i = 0; i < int'(NREG); i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      wr_q     <= wr_d;
      upd_q    <= upd_d;
      shadow_q <= shadow_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign coeff_dat_o    = dat_q;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = upd_q;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Bench for biquad_coeff_sequencer: two instances share one stimulus stream
// (8 channels / gap 1, and 6 channels / gap 4 so out-of-range addresses exist).
// A schedule model derives every output from the commit cycle by arithmetic.
module tb_biquad_coeff_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wr = 1'b0;
  logic [3:0]  reg_addr = '0;
  logic [17:0] reg_dat = '0;
  logic        commit = 1'b0;
  logic [7:0]  mask = '0;
  logic        err_clr = 1'b0;

  logic        busy0, done0, err0;
  logic [17:0] dat0;
  logic [7:0]  wr0, upd0;
  logic        busy1, done1, err1;
  logic [17:0] dat1;
  logic [5:0]  wr1, upd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  biquad_coeff_sequencer u0 (
    .clk(clk), .rst(rst), .reg_wr_i(reg_wr), .reg_addr_i(reg_addr),
    .reg_dat_i(reg_dat), .commit_i(commit), .commit_mask_i(mask),
    .err_clr_i(err_clr), .busy_o(busy0), .done_o(done0), .err_o(err0),
    .coeff_dat_o(dat0), .coeff_wr_o(wr0), .coeff_update_o(upd0)
  );

  biquad_coeff_sequencer #(.NCHAN(6), .UPDATE_GAP(4)) u1 (
    .clk(clk), .rst(rst), .reg_wr_i(reg_wr), .reg_addr_i(reg_addr),
    .reg_dat_i(reg_dat), .commit_i(commit), .commit_mask_i(mask[5:0]),
    .err_clr_i(err_clr), .busy_o(busy1), .done_o(done1), .err_o(err1),
    .coeff_dat_o(dat1), .coeff_wr_o(wr1), .coeff_update_o(upd1)
  );

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // Model state, one slot per instance.
  int unsigned nch_m [2] = '{8, 6};
  int unsigned gap_m [2] = '{1, 4};
  logic [17:0] shadow_m [2][16];
  int unsigned chans_m [2][8];
  int unsigned n_m [2];
  int unsigned c0_m [2];
  bit          active_m [2];
  bit          err_m [2];
  logic        e_busy [2], e_done [2], e_err [2];
  logic [17:0] e_dat [2];
  logic [7:0]  e_wr [2], e_upd [2];
  int unsigned cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 16; a++) shadow_m[i][a] = '0;
      active_m[i] = 0; err_m[i] = 0; n_m[i] = 0; c0_m[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
      e_dat[i] = '0; e_wr[i] = '0; e_upd[i] = '0;
    end
  endtask

  // Model: at each edge apply the sampled inputs, then derive next-cycle outputs.
  initial begin
    bit set_e, busy_now;
    int unsigned rel, p, j, off, ch, n;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        for (int i = 0; i < 2; i++) begin
          set_e = 0;
          busy_now = e_busy[i];
          if (reg_wr) begin
            if (busy_now || 32'(reg_addr) >= nch_m[i] * 2) set_e = 1;
            else shadow_m[i][reg_addr] = reg_dat;
          end
          if (commit) begin
            if (busy_now) set_e = 1;
            else begin
              n = 0;
              for (int c = 0; c < int'(nch_m[i]); c++)
                if (mask[c]) begin chans_m[i][n] = c; n++; end
              if (n > 0) begin active_m[i] = 1; c0_m[i] = cyc; n_m[i] = n; end
            end
          end
          if (set_e) err_m[i] = 1;
          else if (err_clr) err_m[i] = 0;
          e_err[i] = err_m[i];
          e_busy[i] = 0; e_done[i] = 0; e_wr[i] = '0; e_upd[i] = '0;
          if (active_m[i]) begin
            rel = cyc + 1 - c0_m[i];
            p = 2 + gap_m[i] + 2;  // select + coefficients + gap + update
            if (rel <= n_m[i] * p) begin
              j = (rel - 1) / p;
              off = (rel - 1) % p;
              ch = chans_m[i][j];
              e_busy[i] = 1;
              if (off >= 1 && off <= 2) e_wr[i] = 8'(1) << ch;
              if (off == p - 1) e_upd[i] = 8'(1) << ch;
              if (off >= 2 && off <= 3) e_dat[i] = shadow_m[i][ch * 2 + off - 2];
            end else if (rel == n_m[i] * p + 1) begin
              e_done[i] = 1;
            end else begin
              active_m[i] = 0;
            end
          end
        end
      end
      cyc++;
    end
  end

  // Every-cycle compare against the model; reset forces zeros.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_busy", 0, 32'(busy0), 0); chk("rst_wr", 0, 32'(wr0), 0);
        chk("rst_dat", 0, 32'(dat0), 0);   chk("rst_busy", 1, 32'(busy1), 0);
      end else begin
        chk("busy", 0, 32'(busy0), 32'(e_busy[0]));
        chk("done", 0, 32'(done0), 32'(e_done[0]));
        chk("err",  0, 32'(err0),  32'(e_err[0]));
        chk("dat",  0, 32'(dat0),  32'(e_dat[0]));
        chk("wr",   0, 32'(wr0),   32'(e_wr[0]));
        chk("upd",  0, 32'(upd0),  32'(e_upd[0]));
        chk("busy", 1, 32'(busy1), 32'(e_busy[1]));
        chk("done", 1, 32'(done1), 32'(e_done[1]));
        chk("err",  1, 32'(err1),  32'(e_err[1]));
        chk("dat",  1, 32'(dat1),  32'(e_dat[1]));
        chk("wr",   1, 32'({2'b00, wr1}),  32'(e_wr[1]));
        chk("upd",  1, 32'({2'b00, upd1}), 32'(e_upd[1]));
      end
    end
  end

  // Advance to just after the next edge and drop all strobes.
  task automatic tick();
    @(posedge clk); #1;
    reg_wr = 0; commit = 0; err_clr = 0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [17:0] d);
    tick(); reg_wr = 1; reg_addr = a; reg_dat = d;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks k cycles past a commit issued on the current cycle, then samples.
  task automatic to_cycle(input int k);
    ticks(k); @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", 0, 32'(busy0), 0);
    chk("reset_err", 0, 32'(err0), 0);
    chk("reset_dat", 0, 32'(dat0), 0);

    // Single channel, literal timing.
    wr_reg(4'd0, 18'h00100);
    wr_reg(4'd1, 18'h3FF00);
    tick(); commit = 1; mask = 8'h01;
    to_cycle(1); chk("c1_busy", 0, 32'(busy0), 1); chk("c1_wr", 0, 32'(wr0), 0);
    to_cycle(1); chk("c2_wr", 0, 32'(wr0), 32'h01);
    to_cycle(1); chk("c3_wr", 0, 32'(wr0), 32'h01); chk("c3_dat", 0, 32'(dat0), 32'h00100);
    to_cycle(1); chk("c4_wr", 0, 32'(wr0), 0); chk("c4_dat", 0, 32'(dat0), 32'h3FF00);
    to_cycle(1); chk("c5_upd", 0, 32'(upd0), 32'h01); chk("c5_busy", 0, 32'(busy0), 1);
    to_cycle(1); chk("c6_done", 0, 32'(done0), 1); chk("c6_busy", 0, 32'(busy0), 0);
    to_cycle(2); chk("gap4_upd", 1, 32'({2'b00, upd1}), 32'h01);
    to_cycle(1); chk("gap4_done", 1, 32'(done1), 1);
    ticks(4);

    // Two channels: 0 then 7 (instance 1 only sees channel 0).
    wr_reg(4'd14, 18'h01234);
    wr_reg(4'd15, 18'h2ABCD);
    tick(); err_clr = 1;
    tick(); commit = 1; mask = 8'h81;
    to_cycle(7); chk("ch7_wr", 0, 32'(wr0), 32'h80);
    to_cycle(1); chk("ch7_dat0", 0, 32'(dat0), 32'h01234);
    to_cycle(2); chk("ch7_upd", 0, 32'(upd0), 32'h80);
    to_cycle(1); chk("ch7_done", 0, 32'(done0), 1);
    ticks(4);

    // Writes and commits while busy are dropped and flag an error.
    wr_reg(4'd2, 18'h0ABCD);
    wr_reg(4'd3, 18'h20001);
    tick(); commit = 1; mask = 8'h02;
    tick();
    tick(); commit = 1; mask = 8'hFF; reg_wr = 1; reg_addr = 4'd2; reg_dat = 18'h15555;
    to_cycle(1); chk("busy_err", 0, 32'(err0), 1);
    ticks(12);
    tick(); err_clr = 1;
    to_cycle(1); chk("err_clr", 0, 32'(err0), 0);
    tick(); commit = 1; mask = 8'h02;
    to_cycle(3); chk("kept_dat0", 0, 32'(dat0), 32'h0ABCD);
    to_cycle(1); chk("kept_dat1", 0, 32'(dat0), 32'h20001);
    ticks(8);

    // Out-of-range address on the 6-channel instance; empty commit.
    wr_reg(4'd12, 18'h3FFFF);
    to_cycle(1); chk("oor_err", 1, 32'(err1), 1);
    tick(); err_clr = 1;
    tick(); commit = 1; mask = 8'h00;
    to_cycle(1); chk("mask0_busy", 0, 32'(busy0), 0);
    to_cycle(5); chk("mask0_done", 0, 32'(done0), 0);

    // Same-cycle write and commit: the new value is loaded.
    tick(); commit = 1; mask = 8'h01; reg_wr = 1; reg_addr = 4'd0; reg_dat = 18'h12345;
    to_cycle(3); chk("wc_dat", 0, 32'(dat0), 32'h12345);
    ticks(12);

    // Reset during the load of channel 3.
    wr_reg(4'd6, 18'h00777);
    wr_reg(4'd7, 18'h00888);
    tick(); commit = 1; mask = 8'h08;
    to_cycle(2); chk("ld3_wr", 0, 32'(wr0), 32'h08);
    #1 rst = 1;
    #1;
    chk("arst_wr", 0, 32'(wr0), 0); chk("arst_busy", 0, 32'(busy0), 0);
    chk("arst_dat", 0, 32'(dat0), 0);
    ticks(2);
    rst = 0;
    @(negedge clk); chk("post_rst_busy", 0, 32'(busy0), 0);
    tick(); commit = 1; mask = 8'h08;
    to_cycle(2); chk("rl_wr", 0, 32'(wr0), 32'h08);
    to_cycle(1); chk("rl_dat0", 0, 32'(dat0), 0);
    to_cycle(1); chk("rl_dat1", 0, 32'(dat0), 0);
    ticks(10);

    // Randomized traffic, all checked by the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      reg_wr   = ($urandom_range(0, 3) == 0);
      reg_addr = 4'($urandom);
      reg_dat  = 18'($urandom);
      commit   = ($urandom_range(0, 15) == 0);
      mask     = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      err_clr  = ($urandom_range(0, 20) == 0);
    end
    ticks(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
